// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg: shared types and sizing constants for the bit-serial ALU helpers
package serial_alu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int WIDTH_DEF = 32;
  localparam int CNT_W = $clog2(WIDTH_DEF);
endpackage

// File: rtl/sub_1b.sv
// sub_1b: combinational 1-bit full subtractor
module sub_1b (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic d,
  output logic b_out
);
  assign d = a ^ b ^ b_in;
  assign b_out = (~a & b) | (~(a ^ b) & b_in);
endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial LSB-first subtractor (optional add when SERIAL_SUB_ADD_EN is defined)
module serial_sub
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] src0,
  input  logic [WIDTH-1:0] src1,
`ifdef SERIAL_SUB_ADD_EN
  input  logic             op_add,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             b_out,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  state_t state, nxt;
  logic [WIDTH-1:0] a_q, b_q, r_q, r_fin;
  logic [CW-1:0] cnt;
  logic bw, add_q, add_in, d, bn, last, accept;
`ifdef SERIAL_SUB_ADD_EN
  assign add_in = op_add;
`else
  assign add_in = 1'b0;
`endif
  // An add is a subtract of ~b with an inverted carry, so bw holds ~carry in add mode
  sub_1b u_sub (.a(a_q[0]), .b(b_q[0] ^ add_q), .b_in(bw), .d(d), .b_out(bn));
  assign last = cnt == CW'(WIDTH - 1);
  assign accept = start & (state != RUN);
  assign r_fin = {d, r_q[WIDTH-1:1]};
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // next state: DONE behaves like IDLE for start so back-to-back ops have no gap
  always_comb nxt = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  // handshake outputs decoded from state
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  // serial datapath; on the last bit a_q[0]/b_q[0] are the operand MSBs, used for overflow
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
      bw <= 1'b0;
      cnt <= '0;
      add_q <= 1'b0;
      z <= '0;
      b_out <= 1'b0;
      zero <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_q <= src0;
      b_q <= src1;
      bw <= add_in;
      cnt <= '0;
      add_q <= add_in;
    end else if (state == RUN) begin
      a_q <= a_q >> 1;
      b_q <= b_q >> 1;
      r_q <= r_fin;
      bw <= bn;
      cnt <= cnt + 1'b1;
      if (last) begin
        z <= r_fin;
        b_out <= bn ^ add_q;
        zero <= r_fin == '0;
        negative <= d;
        overflow <= (a_q[0] ^ b_q[0] ^ add_q) & (d ^ a_q[0]);
      end
    end
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: scoreboard bench for serial_sub (add ops exercised when SERIAL_SUB_ADD_EN is defined)
module tb_serial_sub;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst, start, op_add;
  logic [W-1:0] src0, src1, z;
  logic busy, done, b_out, zero, negative, overflow;
  typedef struct packed {
    logic [W-1:0] z;
    logic b, zr, ng, ov;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc, bsy;
  always #5 clk = ~clk;
  serial_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .src0(src0), .src1(src1),
`ifdef SERIAL_SUB_ADD_EN
    .op_add(op_add),
`endif
    .busy(busy), .done(done), .z(z), .b_out(b_out), .zero(zero),
    .negative(negative), .overflow(overflow)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic add);
    exp_t e;
    logic [W:0] s;
    s = add ? {1'b0, a} + {1'b0, b} : {1'b0, a} - {1'b0, b};
    e.z = s[W-1:0];
    e.b = add ? s[W] : (a < b);
    e.zr = e.z == '0;
    e.ng = e.z[W-1];
    e.ov = add ? (a[W-1] == b[W-1]) & (e.z[W-1] != a[W-1])
               : (a[W-1] != b[W-1]) & (e.z[W-1] != a[W-1]);
    return e;
  endfunction
  always @(negedge clk)
    if (done) begin
      if (q.size() == 0) check("spurious_done", done, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("z", z, e.z);
        check("b_out", b_out, e.b);
        check("zero", zero, e.zr);
        check("negative", negative, e.ng);
        check("overflow", overflow, e.ov);
        check("busy_in_done", busy, 0);
      end
    end
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic add, input bit push);
    src0 = a;
    src1 = b;
    op_add = add;
    start = 1'b1;
    if (push) q.push_back(model(a, b, add));
  endtask
  task automatic wait_done(output int c, output int bs);
    c = 0;
    bs = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      start = 1'b0;
      c++;
      if (busy) bs++;
      if (done) return;
    end
    check("done_timeout", 0, 1);
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    op_add = 1'b0;
    src0 = '0;
    src1 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_z", z, 0);
    check("rst_flags", {b_out, zero, negative, overflow}, 0);
    do_op(5, 3, 0, 1);
    src0 = 5;
    wait_done(cyc, bsy);
    check("latency", cyc, W + 1);
    check("busy_cycles", bsy, W);
    check("z_5_3", z, 32'h2);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    do_op(3, 5, 0, 1);
    wait_done(cyc, bsy);
    do_op(32'h8000_0000, 32'h1, 0, 1);
    wait_done(cyc, bsy);
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 1);
    wait_done(cyc, bsy);
    do_op(7, 7, 0, 1);
    wait_done(cyc, bsy);
    do_op(10, 4, 0, 1);
    @(negedge clk);
    start = 1'b0;
    src0 = 0;
    src1 = 0;
    repeat (4) @(negedge clk);
    src0 = 9;
    src1 = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bsy);
    do_op(1000, 1, 0, 1);
    wait_done(cyc, bsy);
    check("b2b_gap", cyc, W + 1);
    do_op(100, 50, 0, 0);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_z", z, 0);
    check("mid_rst_flags", {done, b_out, zero, negative, overflow}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    do_op(1, 2, 0, 1);
    wait_done(cyc, bsy);
    for (int i = 0; i < 12; i++) begin
      logic add;
`ifdef SERIAL_SUB_ADD_EN
      add = 1'($urandom_range(1));
`else
      add = 1'b0;
`endif
      do_op($urandom, (i == 0) ? 32'hFFFF_FFFF : $urandom, add, 1);
      wait_done(cyc, bsy);
    end
`ifdef SERIAL_SUB_ADD_EN
    do_op(32'h7FFF_FFFF, 1, 1, 1);
    wait_done(cyc, bsy);
    do_op(32'hFFFF_FFFF, 1, 1, 1);
    wait_done(cyc, bsy);
`endif
    repeat (3) @(negedge clk);
    check("sb_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
